axis_phy_tx: RTL and testbench
==============================

# axis_phy_tx

Downstream TX framing stage of the GT PHY: accepts 32-bit AXI-Stream frames from the test-data generator (or user logic) and converts them into 32-bit 8b/10b-ready GT TX words with K-character framing. Emits an SOF word, the payload, an EOF word carrying the valid byte count of the last beat, then a minimum idle gap. Outputs feed the GT transceiver TX data and charisk ports directly.

## Interface
- P_MIN_GAP, 4, idle words forced after each EOF before the next SOF (legal 1..255)
- i_clk  in  1  GT TX user clock
- i_rst  in  1  asynchronous, active-high reset
- i_axi_s_data  in  32  payload beat; byte0 = [7:0], transmitted first
- i_axi_s_keep  in  4  byte enables; honoured only on last beat
- i_axi_s_last  in  1  last beat of frame
- i_axi_s_valid  in  1  beat valid
- o_axi_s_ready  out  1  beat accepted when valid && ready
- i_gt_tx_done  in  1  GT TX reset done / link up; level
- o_gt_tx_data  out  32  GT TX word
- o_gt_tx_charisk  out  4  per-byte K flag

## Operation
- Words: IDLE = 32'h50BC_50BC, charisk 4'b0101 (K28.5/D16.2 pairs). SOF = 32'h5050_50FB, charisk 4'b0001 (K27.7 in byte0). EOF = {8'h50, 8'h50, cnt, 8'hFD}, charisk 4'b0001 (K29.7 in byte0, byte1 = valid byte count 1..4 of the last data beat). Data words charisk 4'b0000.
- FSM states: S_IDLE, S_DATA, S_EOF, S_GAP. Reset state S_IDLE.
- S_IDLE: output IDLE. If i_gt_tx_done && i_axi_s_valid: register SOF, go S_DATA. Beat not consumed.
- S_DATA: o_axi_s_ready = 1 (combinational: state==S_DATA && i_gt_tx_done). Accepted non-last beat: register data, charisk 0. No beat this cycle (valid low): register IDLE word as fill, stay. Accepted last beat: register data with bytes above cnt zeroed, latch cnt, go S_EOF.
- cnt = index of highest set keep bit + 1 (keep 1111->4, 0111->3, 0011->2, 0001->1, 0101->3 with byte1 passed as-is). keep == 0 on last beat treated as 4'b0001 (cnt 1).
- Non-last beat keep ignored; all 4 bytes transmitted.
- S_EOF: register EOF word, load gap counter (8-bit) with P_MIN_GAP, go S_GAP.
- S_GAP: register IDLE, decrement counter; when counter reaches 1 -> S_IDLE. Ready low.
- Link drop: i_gt_tx_done low in any state -> ready low immediately, next word IDLE, state S_IDLE, gap counter cleared; partial frame abandoned with no EOF.

## Timing
- Reset values: o_gt_tx_data 32'h50BC_50BC, o_gt_tx_charisk 4'b0101, o_axi_s_ready 0, state S_IDLE.
- All GT outputs registered; o_axi_s_ready combinational from state register and i_gt_tx_done.
- Valid seen in S_IDLE at cycle N -> SOF on output N+1, ready high from N+1.
- Beat accepted at cycle M -> on o_gt_tx_data at M+1.
- Last beat accepted at L -> last data L+1, EOF L+2, IDLE L+3..L+2+P_MIN_GAP; earliest next SOF at L+3+P_MIN_GAP (ready first high same cycle).
- Single-beat frame (valid+last on first accepted beat) legal: SOF, data, EOF back-to-back.
- Upstream valid dropping mid-frame never terminates the frame; only last or link drop does.

## Test plan
- 4-beat frame 0x00000001..0x00000004, last keep 1111, P_MIN_GAP=4 -> SOF, 4 data words charisk 0, EOF 32'h5050_04FD, 4 IDLE words, then ready.
- Last beat 0xAABBCCDD keep 0011 -> data word 0x0000CCDD, EOF byte1 = 0x02; keep 0001 -> 0x000000DD, cnt 1.
- Valid low for 3 cycles mid-frame -> 3 IDLE words (charisk 0101) inside frame, payload order intact, single SOF/EOF.
- Back-to-back frames with valid held high -> exactly P_MIN_GAP IDLE words between EOF and next SOF; repeat with P_MIN_GAP=1.
- i_gt_tx_done low after 2nd beat of 5 -> ready low same cycle, next word IDLE, no EOF; after done returns, new frame starts with SOF.
- i_rst asserted mid-frame -> outputs immediately 32'h50BC_50BC / 4'b0101, ready 0; post-reset frame framed correctly.

Source files
------------

// File: rtl/axis_phy_tx_if.sv
// AXI-Stream beat input plus GT TX word output of the PHY TX framer.
`timescale 1ns/1ps
interface axis_phy_tx_if;
    logic [31:0] i_axi_s_data;
    logic [3:0]  i_axi_s_keep;
    logic        i_axi_s_last;
    logic        i_axi_s_valid;
    logic        o_axi_s_ready;
    logic        i_gt_tx_done;
    logic [31:0] o_gt_tx_data;
    logic [3:0]  o_gt_tx_charisk;

    modport slave (
        input  i_axi_s_data,
        input  i_axi_s_keep,
        input  i_axi_s_last,
        input  i_axi_s_valid,
        output o_axi_s_ready,
        input  i_gt_tx_done,
        output o_gt_tx_data,
        output o_gt_tx_charisk
    );

    modport master (
        output i_axi_s_data,
        output i_axi_s_keep,
        output i_axi_s_last,
        output i_axi_s_valid,
        input  o_axi_s_ready,
        output i_gt_tx_done,
        input  o_gt_tx_data,
        input  o_gt_tx_charisk
    );
endinterface

// File: rtl/axis_phy_tx.sv
// GT PHY TX framer: wraps AXI-Stream frames in SOF/EOF K-words
// and enforces a minimum idle gap between frames.
`timescale 1ns/1ps
module axis_phy_tx #(
    parameter int P_MIN_GAP = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    axis_phy_tx_if.slave  bus
);

    localparam logic [31:0] W_IDLE = 32'h50BC_50BC;
    localparam logic [3:0]  K_IDLE = 4'b0101;
    localparam logic [31:0] W_SOF  = 32'h5050_50FB;
    localparam logic [3:0]  K_SOF  = 4'b0001;
    localparam logic [7:0]  B_EOF  = 8'hFD;
    localparam logic [3:0]  K_EOF  = 4'b0001;
    localparam logic [3:0]  K_DATA = 4'b0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_EOF,
        S_GAP
    } state_t;

    state_t      state;
    logic [31:0] tx_data;
    logic [3:0]  tx_k;
    logic [2:0]  cnt_q;
    logic [7:0]  gap_q;

    logic        ready;
    logic        beat;
    logic [2:0]  last_cnt;
    logic [31:0] last_data;

    // Byte count is set by the highest keep bit; an empty keep still
    // carries one byte so the EOF count is never zero.
    function automatic logic [2:0] keep_cnt(input logic [3:0] keep);
        logic [2:0] c;
        if (keep[3])      c = 3'd4;
        else if (keep[2]) c = 3'd3;
        else if (keep[1]) c = 3'd2;
        else              c = 3'd1;
        return c;
    endfunction

    function automatic logic [31:0] cnt_mask(input logic [2:0] c);
        logic [31:0] m;
        unique case (c)
            3'd4:    m = 32'hFFFF_FFFF;
            3'd3:    m = 32'h00FF_FFFF;
            3'd2:    m = 32'h0000_FFFF;
            default: m = 32'h0000_00FF;
        endcase
        return m;
    endfunction

    assign ready     = (state == S_DATA) && bus.i_gt_tx_done;
    assign beat      = ready && bus.i_axi_s_valid;
    assign last_cnt  = keep_cnt(bus.i_axi_s_keep);
    assign last_data = bus.i_axi_s_data & cnt_mask(last_cnt);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= S_IDLE;
            tx_data <= W_IDLE;
            tx_k    <= K_IDLE;
            cnt_q   <= 3'd0;
            gap_q   <= 8'd0;
        end else if (!bus.i_gt_tx_done) begin
            state   <= S_IDLE;
            tx_data <= W_IDLE;
            tx_k    <= K_IDLE;
            gap_q   <= 8'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.i_axi_s_valid) begin
                        tx_data <= W_SOF;
                        tx_k    <= K_SOF;
                        state   <= S_DATA;
                    end else begin
                        tx_data <= W_IDLE;
                        tx_k    <= K_IDLE;
                    end
                end
                S_DATA: begin
                    if (!beat) begin
                        tx_data <= W_IDLE;
                        tx_k    <= K_IDLE;
                    end else if (bus.i_axi_s_last) begin
                        tx_data <= last_data;
                        tx_k    <= K_DATA;
                        cnt_q   <= last_cnt;
                        state   <= S_EOF;
                    end else begin
                        tx_data <= bus.i_axi_s_data;
                        tx_k    <= K_DATA;
                    end
                end
                S_EOF: begin
                    tx_data <= {8'h50, 8'h50, 5'd0, cnt_q, B_EOF};
                    tx_k    <= K_EOF;
                    gap_q   <= 8'(P_MIN_GAP);
                    state   <= S_GAP;
                end
                S_GAP: begin
                    tx_data <= W_IDLE;
                    tx_k    <= K_IDLE;
                    gap_q   <= gap_q - 8'd1;
                    if (gap_q <= 8'd1) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    tx_data <= W_IDLE;
                    tx_k    <= K_IDLE;
                end
            endcase
        end
    end

    assign bus.o_axi_s_ready   = ready;
    assign bus.o_gt_tx_data    = tx_data;
    assign bus.o_gt_tx_charisk = tx_k;

endmodule

// File: tb/tb_axis_phy_tx.sv
// Directed bench for axis_phy_tx: vector table plus gap and reset sequences.
`timescale 1ns/1ps
module tb_axis_phy_tx;

    localparam logic [31:0] IDLE = 32'h50BC_50BC;
    localparam logic [31:0] SOF  = 32'h5050_50FB;
    localparam logic [3:0]  KI   = 4'b0101;
    localparam logic [3:0]  KS   = 4'b0001;
    localparam logic [3:0]  KD   = 4'b0000;

    typedef struct {
        logic        v;
        logic        l;
        logic [3:0]  k;
        logic [31:0] d;
        logic        done;
        logic [31:0] ed;
        logic [3:0]  ek;
        logic        er;
    } vec_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    vec_t tbl[$];

    axis_phy_tx_if bus0();
    axis_phy_tx_if bus1();

    assign bus1.i_axi_s_data  = bus0.i_axi_s_data;
    assign bus1.i_axi_s_keep  = bus0.i_axi_s_keep;
    assign bus1.i_axi_s_last  = bus0.i_axi_s_last;
    assign bus1.i_axi_s_valid = bus0.i_axi_s_valid;
    assign bus1.i_gt_tx_done  = bus0.i_gt_tx_done;

    axis_phy_tx #(.P_MIN_GAP(4)) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus0.slave)
    );

    axis_phy_tx #(.P_MIN_GAP(1)) u_dut1 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic l, input logic [3:0] k,
                       input logic [31:0] d, input logic done,
                       input logic [31:0] ed, input logic [3:0] ek,
                       input logic er);
        vec_t r;
        r.v = v; r.l = l; r.k = k; r.d = d; r.done = done;
        r.ed = ed; r.ek = ek; r.er = er;
        tbl.push_back(r);
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) add(0, 0, 4'hF, 0, 1, IDLE, KI, 0);
    endtask

    // One single-beat frame: SOF, masked data, EOF with count, 4-word gap.
    task automatic add_frame1(input logic [31:0] d, input logic [3:0] k,
                              input logic [31:0] exp_d,
                              input logic [7:0] exp_cnt);
        add(1, 1, k, d, 1, IDLE, KI, 0);
        add(1, 1, k, d, 1, SOF, KS, 1);
        add(0, 0, 4'hF, 0, 1, exp_d, KD, 0);
        add(0, 0, 4'hF, 0, 1, {16'h5050, exp_cnt, 8'hFD}, KS, 0);
        add_idle(4);
    endtask

    // Drive one cycle at a negedge, check just after, advance to next negedge.
    task automatic run(input string tag, input vec_t r);
        bus0.i_axi_s_valid = r.v;
        bus0.i_axi_s_last  = r.l;
        bus0.i_axi_s_keep  = r.k;
        bus0.i_axi_s_data  = r.d;
        bus0.i_gt_tx_done  = r.done;
        #1;
        chk({tag, " data"}, bus0.o_gt_tx_data, r.ed);
        chk({tag, " charisk"}, {28'd0, bus0.o_gt_tx_charisk}, {28'd0, r.ek});
        chk({tag, " ready"}, {31'd0, bus0.o_axi_s_ready}, {31'd0, r.er});
        @(negedge clk);
    endtask

    task automatic run1(input string tag, input logic v, input logic l,
                        input logic [3:0] k, input logic [31:0] d,
                        input logic [31:0] ed, input logic [3:0] ek,
                        input logic er);
        vec_t r;
        r.v = v; r.l = l; r.k = k; r.d = d; r.done = 1'b1;
        r.ed = ed; r.ek = ek; r.er = er;
        run(tag, r);
    endtask

    initial begin
        int g0[$];
        int g1[$];
        int c0, c1;
        bit e0, e1;

        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        bus0.i_axi_s_valid = 1'b0;
        bus0.i_axi_s_last  = 1'b0;
        bus0.i_axi_s_keep  = 4'h0;
        bus0.i_axi_s_data  = 32'h0;
        bus0.i_gt_tx_done  = 1'b1;

        // 4-beat frame, keep 1111
        add(0, 0, 4'hF, 0, 1, IDLE, KI, 0);
        add(1, 0, 4'hF, 1, 1, IDLE, KI, 0);
        add(1, 0, 4'hF, 1, 1, SOF, KS, 1);
        add(1, 0, 4'hF, 2, 1, 1, KD, 1);
        add(1, 0, 4'hF, 3, 1, 2, KD, 1);
        add(1, 1, 4'hF, 4, 1, 3, KD, 1);
        add(0, 0, 4'hF, 0, 1, 4, KD, 0);
        add(0, 0, 4'hF, 0, 1, 32'h5050_04FD, KS, 0);
        add_idle(4);
        // last-beat keep variants
        add_frame1(32'hAABBCCDD, 4'b0011, 32'h0000CCDD, 8'h02);
        add_frame1(32'hAABBCCDD, 4'b0001, 32'h000000DD, 8'h01);
        add_frame1(32'hAABBCCDD, 4'b0101, 32'h00BBCCDD, 8'h03);
        add_frame1(32'hAABBCCDD, 4'b0000, 32'h000000DD, 8'h01);
        // valid low for 3 cycles inside a frame
        add(1, 0, 4'hF, 32'h11, 1, IDLE, KI, 0);
        add(1, 0, 4'hF, 32'h11, 1, SOF, KS, 1);
        add(0, 0, 4'hF, 0, 1, 32'h11, KD, 1);
        add(0, 0, 4'hF, 0, 1, IDLE, KI, 1);
        add(0, 0, 4'hF, 0, 1, IDLE, KI, 1);
        add(1, 1, 4'hF, 32'h22, 1, IDLE, KI, 1);
        add(0, 0, 4'hF, 0, 1, 32'h22, KD, 0);
        add(0, 0, 4'hF, 0, 1, 32'h5050_04FD, KS, 0);
        add_idle(4);
        // link drop after 2nd beat; non-last keep is ignored
        add(1, 0, 4'b0001, 32'hA1A2A3A4, 1, IDLE, KI, 0);
        add(1, 0, 4'b0001, 32'hA1A2A3A4, 1, SOF, KS, 1);
        add(1, 0, 4'hF, 32'hB2, 1, 32'hA1A2A3A4, KD, 1);
        add(1, 0, 4'hF, 32'hB3, 0, 32'hB2, KD, 0);
        add(1, 0, 4'hF, 32'hB3, 0, IDLE, KI, 0);
        add(1, 0, 4'hF, 32'hB3, 1, IDLE, KI, 0);
        add(1, 1, 4'hF, 32'hC1, 1, SOF, KS, 1);
        add(0, 0, 4'hF, 0, 1, 32'hC1, KD, 0);
        add(0, 0, 4'hF, 0, 1, 32'h5050_04FD, KS, 0);
        add_idle(4);

        #3;
        chk("reset data", bus0.o_gt_tx_data, IDLE);
        chk("reset charisk", {28'd0, bus0.o_gt_tx_charisk}, {28'd0, KI});
        chk("reset ready", {31'd0, bus0.o_axi_s_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            run($sformatf("row%0d", i), tbl[i]);
        end

        // reset asserted mid-frame
        run1("rm0", 1, 0, 4'hF, 32'hC1, IDLE, KI, 0);
        run1("rm1", 1, 0, 4'hF, 32'hC1, SOF, KS, 1);
        run1("rm2", 1, 0, 4'hF, 32'hC1, 32'hC1, KD, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst data", bus0.o_gt_tx_data, IDLE);
        chk("midrst charisk", {28'd0, bus0.o_gt_tx_charisk}, {28'd0, KI});
        chk("midrst ready", {31'd0, bus0.o_axi_s_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run1("pr0", 1, 1, 4'hF, 32'hC2, IDLE, KI, 0);
        run1("pr1", 1, 1, 4'hF, 32'hC2, SOF, KS, 1);
        run1("pr2", 0, 0, 4'hF, 32'h0, 32'hC2, KD, 0);
        run1("pr3", 0, 0, 4'hF, 32'h0, 32'h5050_04FD, KS, 0);
        run1("pr4", 0, 0, 4'hF, 32'h0, IDLE, KI, 0);
        for (int i = 0; i < 6; i++) @(negedge clk);

        // back-to-back single-beat frames with valid held high
        bus0.i_axi_s_valid = 1'b1;
        bus0.i_axi_s_last  = 1'b1;
        bus0.i_axi_s_keep  = 4'hF;
        bus0.i_axi_s_data  = 32'h1234_5678;
        e0 = 0; e1 = 0; c0 = 0; c1 = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            #1;
            if (bus0.o_gt_tx_data == 32'h5050_04FD) begin
                e0 = 1; c0 = 0;
            end else if (e0 && bus0.o_gt_tx_data == IDLE) begin
                c0++;
            end else if (e0 && bus0.o_gt_tx_data == SOF) begin
                g0.push_back(c0); e0 = 0;
            end
            if (bus1.o_gt_tx_data == 32'h5050_04FD) begin
                e1 = 1; c1 = 0;
            end else if (e1 && bus1.o_gt_tx_data == IDLE) begin
                c1++;
            end else if (e1 && bus1.o_gt_tx_data == SOF) begin
                g1.push_back(c1); e1 = 0;
            end
            @(negedge clk);
        end
        bus0.i_axi_s_valid = 1'b0;
        chk("gap4 frames seen", {31'd0, g0.size() >= 3}, 32'd1);
        chk("gap1 frames seen", {31'd0, g1.size() >= 3}, 32'd1);
        foreach (g0[i]) chk($sformatf("gap4 idle count %0d", i), g0[i], 4);
        foreach (g1[i]) chk($sformatf("gap1 idle count %0d", i), g1[i], 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
